wb_commit_stage: RTL and testbench
==================================

# wb_commit_stage

Parametrised, multi-lane successor to the single-lane write-back stage. It buffers up to DEPTH issue groups of LANES instructions each and retires the head group in program order. It handles register-file writes, exception/ertn/refetch flush generation, CSR exception-field encoding and a retired-instruction counter. It sits between the memory stage and the register file / CSR unit.

## Interface
- LANES, 2, lanes per group (1..4); lane 0 is oldest.
- DEPTH, 4, group buffer depth (power of 2, ≥2).
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- in_valid  in  LANES  per-lane valid of the offered group; the group is offered when any bit is set.
- in_ready  out  1  buffer not full.
- in_pc, in_result, in_error_va  in  LANES×32  per-lane PC, GR result, faulting VA.
- in_dest  in  LANES×5; in_gr_we, in_excp, in_ertn, in_refetch  in  LANES each.
- in_excp_num  in  LANES×16  exception vector, same bit encoding as the current excp_num.
- commit_stall  in  1  hold head group (TLB search/read in progress).
- rf_we  out  LANES; rf_waddr  out  LANES×5; rf_wdata  out  LANES×32.
- excp_flush, ertn_flush, refetch_flush  out  1 each.
- csr_era  out  32; csr_ecode  out  6; csr_esubcode  out  9.
- va_error  out  1; bad_va  out  32.
- excp_tlbrefill, excp_tlb  out  1 each; excp_tlb_vppn  out  19.
- retire_cnt  out  $clog2(LANES+1)  instructions retired this cycle.
- retired_total  out  64  running retired count.

## Operation
- Buffer: circular queue of DEPTH group entries. Each entry stores all lane fields and in_valid.
- Push: in_valid≠0 && in_ready && !flush. Push into a full buffer is impossible (in_ready=0).
- Commit: head present && !commit_stall. All head-group outputs are combinational from the head entry.
- Cut lane k = lowest valid lane with excp|ertn|refetch. If none, k = LANES.
- Lanes < k retire normally.
- Lane k behaviour:
  - excp: no GR write; excp_flush=1.
  - else ertn: retires; ertn_flush=1.
  - else refetch: retires with GR write; refetch_flush=1.
- Lanes > k are discarded.
- csr_era = pc of lane k; otherwise pc of lane 0.
- Flush (any *_flush) empties the whole buffer at the next edge, including a same-cycle push.
- GR write: rf_we[i] = valid && gr_we && retiring && !excp. If two retiring lanes share a nonzero dest, only the younger write is enabled.
- Exception fields come from lane k's excp_num. Priority is bit 0 highest to bit 15 lowest:
  - bit 0 INT: no va_error.
  - bit 1 ADEF: bad_va = pc, esubcode ADEF.
  - bits 2–4 TLBR/PIF/PPI: bad_va = pc, vppn = pc[31:13], excp_tlb=1, refill only for bit 2.
  - bits 5–8 SYS/BRK/INE/IPE: no va_error.
  - bit 9 ALE: bad_va = error_va.
  - bit 10 ADEM: bad_va = error_va, esubcode ADEM.
  - bits 11–15 TLBR/PME/PPI/PIS/PIL: bad_va = error_va, vppn = error_va[31:13], excp_tlb=1, refill only for bit 11.
- All exception outputs are zero when excp_flush=0.
- retire_cnt = number of retiring lanes. An excepting lane is not counted; ertn/refetch lanes are counted.
- retired_total += retire_cnt each commit cycle; wraps modulo 2^64.

## Timing
- Reset: buffer empty, pointers 0, retired_total 0.
  - Hence in_ready=1 and every other output is 0.
- Latency: group pushed at edge N is visible at head during cycle N+1. With an empty buffer and no stall it commits that same cycle.
- Throughput: one group per cycle. Simultaneous push and commit keeps occupancy unchanged.
- in_ready = occupancy<DEPTH, registered-state based; a commit in the same cycle does not raise it.
- commit_stall holds every output at 0 and keeps the head intact; pushes continue until full.
- Flush outputs are single-cycle pulses. The cycle after a flush, the buffer is empty.
- Reset mid-operation clears the buffer immediately (asynchronous reset). No partial commit is emitted.
- Pointer wrap uses an extra MSB so full and empty are distinguishable.

## Structure
- Shared package: ECODE_*/ESUBCODE_* constants (from csr.h), excp_num bit indices, a group-entry struct/width macro.
- Sub-module `excp_encode`: one lane's excp_num/pc/error_va → ecode, esubcode, va_error, bad_va, tlbrefill, tlb, vppn. Purely combinational; instantiated once on the lane-k mux output.
- Top module: queue, cut-lane priority finder, GR write-collision masking, counters.

## Test plan
- LANES=2: push group {lane0 r5=0x11, lane1 r6=0x22}, no stall → next cycle rf_we=2'b11, waddr 5/6, retire_cnt=2; retired_total=2 afterwards.
- Both lanes write r7 (0xA, 0xB) → rf_we=2'b10, r7 receives 0xB.
- Lane0 excp_num bit 11, error_va 0x8000_3000 → excp_flush=1, ecode TLBR, bad_va 0x8000_3000, excp_tlbrefill=1, vppn 0x40001, rf_we=0, retire_cnt=0; buffer empty next cycle.
- Lane0 normal, lane1 refetch, then two more groups queued → lane0 and lane1 write, refetch_flush=1, csr_era = lane1 pc, queued groups dropped.
- commit_stall high while pushing 5 groups with DEPTH=4 → in_ready falls after the 4th push; deassert stall → 4 groups retire over consecutive cycles, in order.
- Assert reset mid-stream with 3 groups buffered → outputs 0 immediately, in_ready=1, retired_total=0.

Source files
------------

// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the multi-lane commit stage: CSR exception codes,
// excp_num bit positions and the per-lane buffer entry.
package wb_commit_stage_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;
  localparam logic [5:0] ECODE_IPE  = 6'h0e;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  // Bit positions in excp_num, lowest index has highest priority.
  localparam int EXCP_INT    = 0;
  localparam int EXCP_ADEF   = 1;
  localparam int EXCP_TLBR_F = 2;
  localparam int EXCP_PIF    = 3;
  localparam int EXCP_PPI_F  = 4;
  localparam int EXCP_SYS    = 5;
  localparam int EXCP_BRK    = 6;
  localparam int EXCP_INE    = 7;
  localparam int EXCP_IPE    = 8;
  localparam int EXCP_ALE    = 9;
  localparam int EXCP_ADEM   = 10;
  localparam int EXCP_TLBR_M = 11;
  localparam int EXCP_PME    = 12;
  localparam int EXCP_PPI_M  = 13;
  localparam int EXCP_PIS    = 14;
  localparam int EXCP_PIL    = 15;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] error_va;
    logic [4:0]  dest;
    logic        gr_we;
    logic        excp;
    logic        ertn;
    logic        refetch;
    logic [15:0] excp_num;
  } lane_t;

  localparam int LANE_W = $bits(lane_t);

endpackage

// File: rtl/wb_commit_stage_excp_encode.sv
// Encodes one lane's exception vector into CSR ESTAT/BADV/TLBEHI fields.
module excp_encode
  import wb_commit_stage_pkg::*;
(
  input  logic [15:0] excp_num,
  input  logic [31:0] pc,
  input  logic [31:0] error_va,
  output logic [5:0]  ecode,
  output logic [8:0]  esubcode,
  output logic        va_error,
  output logic [31:0] bad_va,
  output logic        tlbrefill,
  output logic        tlb,
  output logic [18:0] vppn
);

  always_comb begin
    ecode     = '0;
    esubcode  = '0;
    va_error  = 1'b0;
    bad_va    = '0;
    tlbrefill = 1'b0;
    tlb       = 1'b0;
    vppn      = '0;
    if (excp_num[EXCP_INT]) begin
      ecode = ECODE_INT;
    end else if (excp_num[EXCP_ADEF]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUBCODE_ADEF;
      va_error = 1'b1;
      bad_va   = pc;
    end else if (excp_num[EXCP_TLBR_F] || excp_num[EXCP_PIF] || excp_num[EXCP_PPI_F]) begin
      // Fetch-side TLB faults report the instruction address itself.
      ecode     = excp_num[EXCP_TLBR_F] ? ECODE_TLBR :
                  excp_num[EXCP_PIF]    ? ECODE_PIF  : ECODE_PPI;
      va_error  = 1'b1;
      bad_va    = pc;
      tlb       = 1'b1;
      tlbrefill = excp_num[EXCP_TLBR_F];
      vppn      = pc[31:13];
    end else if (excp_num[EXCP_SYS]) begin
      ecode = ECODE_SYS;
    end else if (excp_num[EXCP_BRK]) begin
      ecode = ECODE_BRK;
    end else if (excp_num[EXCP_INE]) begin
      ecode = ECODE_INE;
    end else if (excp_num[EXCP_IPE]) begin
      ecode = ECODE_IPE;
    end else if (excp_num[EXCP_ALE]) begin
      ecode    = ECODE_ALE;
      va_error = 1'b1;
      bad_va   = error_va;
    end else if (excp_num[EXCP_ADEM]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUBCODE_ADEM;
      va_error = 1'b1;
      bad_va   = error_va;
    end else if (excp_num[15:11] != 5'b0) begin
      // Data-side TLB faults report the memory access address.
      ecode     = excp_num[EXCP_TLBR_M] ? ECODE_TLBR :
                  excp_num[EXCP_PME]    ? ECODE_PME  :
                  excp_num[EXCP_PPI_M]  ? ECODE_PPI  :
                  excp_num[EXCP_PIS]    ? ECODE_PIS  : ECODE_PIL;
      va_error  = 1'b1;
      bad_va    = error_va;
      tlb       = 1'b1;
      tlbrefill = excp_num[EXCP_TLBR_M];
      vppn      = error_va[31:13];
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Multi-lane write-back/commit stage: buffers issue groups and retires the
// head group in program order, generating RF writes, flushes and CSR fields.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             in_valid,
  output logic                         in_ready,
  input  logic [LANES*32-1:0]          in_pc,
  input  logic [LANES*32-1:0]          in_result,
  input  logic [LANES*32-1:0]          in_error_va,
  input  logic [LANES*5-1:0]           in_dest,
  input  logic [LANES-1:0]             in_gr_we,
  input  logic [LANES-1:0]             in_excp,
  input  logic [LANES-1:0]             in_ertn,
  input  logic [LANES-1:0]             in_refetch,
  input  logic [LANES*16-1:0]          in_excp_num,
  input  logic                         commit_stall,
  output logic [LANES-1:0]             rf_we,
  output logic [LANES*5-1:0]           rf_waddr,
  output logic [LANES*32-1:0]          rf_wdata,
  output logic                         excp_flush,
  output logic                         ertn_flush,
  output logic                         refetch_flush,
  output logic [31:0]                  csr_era,
  output logic [5:0]                   csr_ecode,
  output logic [8:0]                   csr_esubcode,
  output logic                         va_error,
  output logic [31:0]                  bad_va,
  output logic                         excp_tlbrefill,
  output logic                         excp_tlb,
  output logic [18:0]                  excp_tlb_vppn,
  output logic [$clog2(LANES+1)-1:0]   retire_cnt,
  output logic [63:0]                  retired_total
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LANES+1);

  lane_t            mem [DEPTH][LANES];
  lane_t            in_lane [LANES];
  lane_t            head [LANES];
  logic [PTR_W:0]   rptr, wptr;
  logic [PTR_W-1:0] ridx, widx;
  logic             empty, full, push, commit, flush;
  logic [LANES-1:0] retiring, cand;
  logic             seen;
  logic [31:0]      cut_pc, cut_va;
  logic [15:0]      cut_num;

  // Handshake: a group transfers on a clock edge when |in_valid && in_ready
  // and no flush is leaving the stage that cycle; in_ready depends only on
  // registered occupancy, never on the same-cycle commit.
  assign ridx     = rptr[PTR_W-1:0];
  assign widx     = wptr[PTR_W-1:0];
  assign empty    = (rptr == wptr);
  assign full     = (rptr[PTR_W] != wptr[PTR_W]) && (ridx == widx);
  assign in_ready = !full;
  assign commit   = !empty && !commit_stall;
  assign flush    = excp_flush || ertn_flush || refetch_flush;
  assign push     = (|in_valid) && !full && !flush;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      in_lane[i].valid    = in_valid[i];
      in_lane[i].pc       = in_pc[i*32 +: 32];
      in_lane[i].result   = in_result[i*32 +: 32];
      in_lane[i].error_va = in_error_va[i*32 +: 32];
      in_lane[i].dest     = in_dest[i*5 +: 5];
      in_lane[i].gr_we    = in_gr_we[i];
      in_lane[i].excp     = in_excp[i];
      in_lane[i].ertn     = in_ertn[i];
      in_lane[i].refetch  = in_refetch[i];
      in_lane[i].excp_num = in_excp_num[i*16 +: 16];
      head[i]             = mem[ridx][i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < LANES; i++) mem[widx][i] <= in_lane[i];
    end
  end

  // Walk lanes oldest first; the first valid excp/ertn/refetch lane is the cut.
  always_comb begin
    seen          = 1'b0;
    retiring      = '0;
    cand          = '0;
    cut_pc        = '0;
    cut_va        = '0;
    cut_num       = '0;
    excp_flush    = 1'b0;
    ertn_flush    = 1'b0;
    refetch_flush = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (commit && head[i].valid && !seen) begin
        if (head[i].excp || head[i].ertn || head[i].refetch) begin
          seen    = 1'b1;
          cut_pc  = head[i].pc;
          cut_va  = head[i].error_va;
          cut_num = head[i].excp_num;
          if (head[i].excp) begin
            excp_flush = 1'b1;
          end else begin
            retiring[i] = 1'b1;
            if (head[i].ertn) ertn_flush = 1'b1;
            else              refetch_flush = 1'b1;
          end
        end else begin
          retiring[i] = 1'b1;
        end
      end
      cand[i] = retiring[i] && head[i].gr_we;
    end
  end

  // A younger retiring write to the same nonzero register wins.
  always_comb begin
    rf_we      = '0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    retire_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      rf_we[i] = cand[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (cand[j] && head[j].dest == head[i].dest && head[i].dest != 5'd0)
          rf_we[i] = 1'b0;
      end
      if (rf_we[i]) begin
        rf_waddr[i*5 +: 5]   = head[i].dest;
        rf_wdata[i*32 +: 32] = head[i].result;
      end
      retire_cnt = retire_cnt + CNT_W'(retiring[i]);
    end
  end

  assign csr_era = !commit ? 32'd0 : (seen ? cut_pc : head[0].pc);

  logic [5:0]  enc_ecode;
  logic [8:0]  enc_esubcode;
  logic        enc_va_error, enc_tlbrefill, enc_tlb;
  logic [31:0] enc_bad_va;
  logic [18:0] enc_vppn;

  excp_encode u_excp_encode (
    .excp_num  (cut_num),
    .pc        (cut_pc),
    .error_va  (cut_va),
    .ecode     (enc_ecode),
    .esubcode  (enc_esubcode),
    .va_error  (enc_va_error),
    .bad_va    (enc_bad_va),
    .tlbrefill (enc_tlbrefill),
    .tlb       (enc_tlb),
    .vppn      (enc_vppn)
  );

  assign csr_ecode      = excp_flush ? enc_ecode     : 6'd0;
  assign csr_esubcode   = excp_flush ? enc_esubcode  : 9'd0;
  assign va_error       = excp_flush && enc_va_error;
  assign bad_va         = excp_flush ? enc_bad_va    : 32'd0;
  assign excp_tlbrefill = excp_flush && enc_tlbrefill;
  assign excp_tlb       = excp_flush && enc_tlb;
  assign excp_tlb_vppn  = excp_flush ? enc_vppn      : 19'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr          <= '0;
      wptr          <= '0;
      retired_total <= '0;
    end else begin
      if (flush) begin
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (push)   wptr <= wptr + (PTR_W+1)'(1);
        if (commit) rptr <= rptr + (PTR_W+1)'(1);
      end
      if (commit) retired_total <= retired_total + 64'(retire_cnt);
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage with LANES=2, DEPTH=4.
module tb_wb_commit_stage;
  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    in_valid;
  logic          in_ready;
  logic [63:0]   in_pc, in_result, in_error_va;
  logic [9:0]    in_dest;
  logic [1:0]    in_gr_we, in_excp, in_ertn, in_refetch;
  logic [31:0]   in_excp_num;
  logic          commit_stall;
  logic [1:0]    rf_we;
  logic [9:0]    rf_waddr;
  logic [63:0]   rf_wdata;
  logic          excp_flush, ertn_flush, refetch_flush;
  logic [31:0]   csr_era;
  logic [5:0]    csr_ecode;
  logic [8:0]    csr_esubcode;
  logic          va_error;
  logic [31:0]   bad_va;
  logic          excp_tlbrefill, excp_tlb;
  logic [18:0]   excp_tlb_vppn;
  logic [1:0]    retire_cnt;
  logic [63:0]   retired_total;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_commit_stage #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_error_va(in_error_va),
    .in_dest(in_dest), .in_gr_we(in_gr_we), .in_excp(in_excp), .in_ertn(in_ertn),
    .in_refetch(in_refetch), .in_excp_num(in_excp_num), .commit_stall(commit_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
    .csr_era(csr_era), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
    .va_error(va_error), .bad_va(bad_va), .excp_tlbrefill(excp_tlbrefill),
    .excp_tlb(excp_tlb), .excp_tlb_vppn(excp_tlb_vppn),
    .retire_cnt(retire_cnt), .retired_total(retired_total)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = '0; in_pc = '0; in_result = '0; in_error_va = '0; in_dest = '0;
    in_gr_we = '0; in_excp = '0; in_ertn = '0; in_refetch = '0; in_excp_num = '0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [4:0] dest,
                          input logic [31:0] res, input logic gr_we, input logic [15:0] num,
                          input logic [31:0] va, input logic ertn, input logic refetch);
    in_valid[i]            = 1'b1;
    in_pc[i*32 +: 32]      = pc;
    in_dest[i*5 +: 5]      = dest;
    in_result[i*32 +: 32]  = res;
    in_gr_we[i]            = gr_we;
    in_excp_num[i*16 +: 16] = num;
    in_excp[i]             = |num;
    in_error_va[i*32 +: 32] = va;
    in_ertn[i]             = ertn;
    in_refetch[i]          = refetch;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    commit_stall = 1'b0;
    #2;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_retire_cnt", retire_cnt, 0);
    chk("reset_total", retired_total, 0);
    chk("reset_era", csr_era, 0);
    chk("reset_excp_flush", excp_flush, 0);

    // Two independent writes retire the cycle after the push.
    tick(); reset = 1'b0;
    set_lane(0, 32'h1000, 5'd5, 32'h11, 1, 16'h0, 0, 0, 0);
    set_lane(1, 32'h1004, 5'd6, 32'h22, 1, 16'h0, 0, 0, 0);
    #1 chk("g1_empty_rf_we", rf_we, 0);
    tick(); clear_in();
    #1 chk("g1_rf_we", rf_we, 2'b11);
    chk("g1_waddr", rf_waddr, {5'd6, 5'd5});
    chk("g1_wdata", rf_wdata, {32'h22, 32'h11});
    chk("g1_retire_cnt", retire_cnt, 2);
    chk("g1_era", csr_era, 32'h1000);
    chk("g1_total_before", retired_total, 0);

    // Same destination in both lanes: only the younger write survives.
    tick();
    set_lane(0, 32'h2000, 5'd7, 32'hA, 1, 16'h0, 0, 0, 0);
    set_lane(1, 32'h2004, 5'd7, 32'hB, 1, 16'h0, 0, 0, 0);
    #1 chk("g1_total_after", retired_total, 2);
    chk("idle_rf_we", rf_we, 0);
    tick(); clear_in();
    #1 chk("coll_rf_we", rf_we, 2'b10);
    chk("coll_waddr", rf_waddr, {5'd7, 5'd0});
    chk("coll_wdata", rf_wdata, {32'hB, 32'h0});
    chk("coll_retire_cnt", retire_cnt, 2);

    // Data TLB refill on lane 0; a same-cycle push must be dropped.
    tick();
    set_lane(0, 32'h3000, 5'd8, 32'h88, 1, 16'h0800, 32'h8000_3000, 0, 0);
    set_lane(1, 32'h3004, 5'd9, 32'h99, 1, 16'h0, 0, 0, 0);
    #1 chk("coll_total", retired_total, 4);
    tick(); clear_in();
    set_lane(0, 32'h3100, 5'd3, 32'h33, 1, 16'h0, 0, 0, 0);
    #1 chk("tlbr_excp_flush", excp_flush, 1);
    chk("tlbr_ecode", csr_ecode, 6'h3f);
    chk("tlbr_esubcode", csr_esubcode, 0);
    chk("tlbr_va_error", va_error, 1);
    chk("tlbr_bad_va", bad_va, 32'h8000_3000);
    chk("tlbr_refill", excp_tlbrefill, 1);
    chk("tlbr_tlb", excp_tlb, 1);
    chk("tlbr_vppn", excp_tlb_vppn, 19'h40001);
    chk("tlbr_rf_we", rf_we, 0);
    chk("tlbr_retire_cnt", retire_cnt, 0);
    chk("tlbr_era", csr_era, 32'h3000);
    chk("tlbr_ertn_flush", ertn_flush, 0);
    tick(); clear_in();
    #1 chk("tlbr_after_rf_we", rf_we, 0);
    chk("tlbr_after_flush", excp_flush, 0);
    chk("tlbr_after_retire", retire_cnt, 0);
    chk("tlbr_after_ready", in_ready, 1);
    chk("tlbr_after_total", retired_total, 4);

    // Refetch on lane 1 with two younger groups queued behind it.
    tick(); commit_stall = 1'b1;
    set_lane(0, 32'h4000, 5'd10, 32'h55, 1, 16'h0, 0, 0, 0);
    set_lane(1, 32'h4004, 5'd11, 32'h66, 1, 16'h0, 0, 0, 1);
    tick(); clear_in();
    set_lane(0, 32'h5000, 5'd12, 32'h77, 1, 16'h0, 0, 0, 0);
    #1 chk("stall_rf_we", rf_we, 0);
    chk("stall_era", csr_era, 0);
    chk("stall_refetch", refetch_flush, 0);
    tick(); clear_in();
    set_lane(0, 32'h5100, 5'd13, 32'h78, 1, 16'h0, 0, 0, 0);
    #1 chk("stall_ready", in_ready, 1);
    tick(); clear_in(); commit_stall = 1'b0;
    #1 chk("rf_rf_we", rf_we, 2'b11);
    chk("rf_flush", refetch_flush, 1);
    chk("rf_era", csr_era, 32'h4004);
    chk("rf_retire_cnt", retire_cnt, 2);
    chk("rf_waddr", rf_waddr, {5'd11, 5'd10});
    chk("rf_wdata", rf_wdata, {32'h66, 32'h55});
    chk("rf_excp_flush", excp_flush, 0);
    tick();
    #1 chk("rf_dropped_rf_we", rf_we, 0);
    chk("rf_dropped_retire", retire_cnt, 0);
    chk("rf_total", retired_total, 6);

    // Fill under stall: the fifth group is refused, four drain in order.
    commit_stall = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick(); clear_in();
      set_lane(0, 32'h6000 + 32'(4*j), 5'(1+j), 32'h100 + 32'(j), 1, 16'h0, 0, 0, 0);
      #1 chk($sformatf("fill_ready_%0d", j), in_ready, (j < 4) ? 1 : 0);
    end
    tick(); clear_in(); commit_stall = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1 chk($sformatf("drain_rf_we_%0d", j), rf_we, 2'b01);
      chk($sformatf("drain_waddr_%0d", j), rf_waddr, 10'(1 + j));
      chk($sformatf("drain_wdata_%0d", j), rf_wdata, 64'h100 + 64'(j));
      chk($sformatf("drain_retire_%0d", j), retire_cnt, 1);
      if (j == 0) chk("drain_full_ready", in_ready, 0);
      tick();
    end
    #1 chk("drain_empty_rf_we", rf_we, 0);
    chk("drain_total", retired_total, 10);
    chk("drain_ready", in_ready, 1);

    // Asynchronous reset with three groups buffered.
    commit_stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick(); clear_in();
      set_lane(0, 32'h7f00 + 32'(4*j), 5'(20+j), 32'h200 + 32'(j), 1, 16'h0, 0, 0, 0);
    end
    tick(); clear_in();
    #2 reset = 1'b1; commit_stall = 1'b0;
    #1 chk("mid_reset_rf_we", rf_we, 0);
    chk("mid_reset_retire", retire_cnt, 0);
    chk("mid_reset_ready", in_ready, 1);
    chk("mid_reset_total", retired_total, 0);
    chk("mid_reset_era", csr_era, 0);
    tick(); reset = 1'b0;
    #1 chk("post_reset_rf_we", rf_we, 0);

    // ADEM beats PME on lane 1; lane 0 still retires.
    tick();
    set_lane(0, 32'h7000, 5'd2, 32'h21, 1, 16'h0, 0, 0, 0);
    set_lane(1, 32'h7004, 5'd3, 32'h31, 1, 16'h1400, 32'h1234_5678, 0, 0);
    tick(); clear_in();
    #1 chk("adem_flush", excp_flush, 1);
    chk("adem_retire", retire_cnt, 1);
    chk("adem_rf_we", rf_we, 2'b01);
    chk("adem_era", csr_era, 32'h7004);
    chk("adem_ecode", csr_ecode, 6'h08);
    chk("adem_esub", csr_esubcode, 9'h001);
    chk("adem_bad_va", bad_va, 32'h1234_5678);
    chk("adem_tlb", excp_tlb, 0);
    chk("adem_vppn", excp_tlb_vppn, 0);

    // Fetch PIF on lane 0: address fields come from the PC.
    tick();
    set_lane(0, 32'h0002_4000, 5'd4, 32'h41, 1, 16'h0008, 32'hdead_0000, 0, 0);
    set_lane(1, 32'h0002_4004, 5'd5, 32'h51, 1, 16'h0, 0, 0, 0);
    tick(); clear_in();
    #1 chk("pif_ecode", csr_ecode, 6'h03);
    chk("pif_bad_va", bad_va, 32'h0002_4000);
    chk("pif_tlb", excp_tlb, 1);
    chk("pif_refill", excp_tlbrefill, 0);
    chk("pif_vppn", excp_tlb_vppn, 19'h12);
    chk("pif_retire", retire_cnt, 0);

    // ertn on lane 0 retires; lane 1 is discarded.
    tick();
    set_lane(0, 32'h8000, 5'd0, 32'h0, 0, 16'h0, 0, 1, 0);
    set_lane(1, 32'h8004, 5'd4, 32'h44, 1, 16'h0, 0, 0, 0);
    tick(); clear_in();
    #1 chk("ertn_flush", ertn_flush, 1);
    chk("ertn_excp_flush", excp_flush, 0);
    chk("ertn_retire", retire_cnt, 1);
    chk("ertn_rf_we", rf_we, 0);
    chk("ertn_era", csr_era, 32'h8000);
    chk("ertn_ecode", csr_ecode, 0);
    tick();
    #1 chk("final_total", retired_total, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
